// File: rtl/scholar_dmem_responder.sv
// Data-memory responder for the SCHOLAR core d_m_* port: byte-masked word array
// answered after a fixed wait count. Define DMEM_RANDOM_STALL_EN to add 0..3 LFSR stall cycles.
module scholar_dmem_responder #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int DepthWords = 1024,
  parameter int Latency    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   d_m_addr_i,
  input  logic                   d_m_rden_i,
  input  logic                   d_m_wren_i,
  input  logic [DataWidth-1:0]   d_m_wdata_i,
  input  logic [DataWidth/8-1:0] d_m_wmask_i,
  output logic [DataWidth-1:0]   d_m_rdata_o,
  output logic                   d_m_hit_o,
  output logic                   busy_o
);

  localparam int ByteCnt = DataWidth / 8;
  localparam int OffBits = $clog2(ByteCnt);
  localparam int IdxBits = $clog2(DepthWords);
  localparam int CntW    = 5;

  if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_width
    $fatal(1, "scholar_dmem_responder: DataWidth must be 32 or 64");
  end
  if (Latency < 0 || Latency > 15) begin : g_bad_latency
    $fatal(1, "scholar_dmem_responder: Latency must be 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      wait_init;
  logic [IdxBits-1:0]   idx_q, req_idx, rd_idx;
  logic [DataWidth-1:0] wdata_q;
  logic [ByteCnt-1:0]   wmask_q;
  logic                 is_wr_q;
  logic                 capture, rd_fire, wr_fire;
  logic                 unused_addr;

  logic [DataWidth-1:0] mem [DepthWords];

  assign req_idx     = d_m_addr_i[OffBits +: IdxBits];
  // Byte-offset and aliasing upper address bits are deliberately dropped.
  assign unused_addr = ^d_m_addr_i;

`ifdef DMEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign wait_init = CntW'(Latency) + CntW'(lfsr_q[1:0]);
`else
  assign wait_init = CntW'(Latency);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (d_m_rden_i || d_m_wren_i) begin
          capture = 1'b1;
          cnt_d   = wait_init;
          state_d = (wait_init != '0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A direct IDLE->RESP read uses the live request; otherwise the captured one.
  assign rd_idx  = (state_q == S_IDLE) ? req_idx : idx_q;
  assign rd_fire = (state_d == S_RESP) && (state_q != S_RESP) &&
                   ((state_q == S_IDLE) ? (d_m_rden_i && !d_m_wren_i) : !is_wr_q);
  assign wr_fire = (state_q == S_RESP) && is_wr_q && !rst_i;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      is_wr_q     <= 1'b0;
      d_m_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= req_idx;
        wdata_q <= d_m_wdata_i;
        wmask_q <= d_m_wmask_i;
        is_wr_q <= d_m_wren_i;
      end
      if (rd_fire) d_m_rdata_o <= mem[rd_idx];
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; only the write
  // enable is gated by reset, which discards a store caught by reset in RESP.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < ByteCnt; b++) begin
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign d_m_hit_o = (state_q == S_RESP);
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_scholar_dmem_responder.sv
// Self-checking bench for scholar_dmem_responder: directed vector table, reset
// corner cases, and randomized traffic against a word-array reference model.
module tb_scholar_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_RANDOM_STALL_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        rden, wren, hit, busy;
  logic [3:0]  wmask;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  scholar_dmem_responder #(
    .DataWidth(32), .AddrWidth(32), .DepthWords(1024), .Latency(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .d_m_addr_i(addr), .d_m_rden_i(rden), .d_m_wren_i(wren),
    .d_m_wdata_i(wdata), .d_m_wmask_i(wmask),
    .d_m_rdata_o(rdata), .d_m_hit_o(hit), .busy_o(busy)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: a write merges enabled bytes; a read (not also a write) loads rdata.
  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m);
    int i;
    i = int'(a[11:2]);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
    end else if (rd) begin
      ref_rdata = ref_mem[i];
    end
  endtask

  // Issues one request, scrambles the bus after capture, and measures hit latency.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output int lat, output logic [31:0] rd_val);
    addr = a; wdata = d; wmask = m; rden = rd; wren = wr;
    lat = 0;
    rd_val = 'x;
    tick();
    check("busy_active", busy, 1'b1);
    addr  = a ^ 32'h0000_0FFC;
    wdata = ~d;
    wmask = ~m;
    for (int k = 1; k <= 40; k++) begin
      if (hit) begin
        lat = k;
        rd_val = rdata;
        break;
      end
      tick();
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL hit_timeout: got no hit expected hit within 40 cycles");
    end
    tick();
    rden = 1'b0;
    wren = 1'b0;
    check("hit_one_cycle", hit, 1'b0);
    check("busy_idle", busy, 1'b0);
    model_apply(rd, wr, a, d, m);
  endtask

  vec_t        vecs [12];
  int          lat;
  logic [31:0] got;
  logic        saw_hit;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0005, 4'hF, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0005};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0077, 4'hF, 32'h0000_0005};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0077};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0000_0077};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_0000, 4'h0, 32'h0000_0077};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_F011, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};

    addr = '0; wdata = '0; wmask = '0; rden = 1'b0; wren = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    ref_rdata = '0;
    check("rst_hit", hit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 32'h0);

    foreach (vecs[i]) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask, lat, got);
      check_range($sformatf("vec%0d_lat", i), lat, LAT + 1, LAT + 1 + EXTRA);
      check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
    end

    // Reset while waiting: no hit, idle at once, store never lands.
    do_txn(1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, lat, got);
    addr = 32'h40; wdata = 32'hCAFE_F00D; wmask = 4'hF; wren = 1'b1;
    tick();
    wren = 1'b0;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    ref_rdata = '0;
    check("rst_wait_hit", hit, 1'b0);
    check("rst_wait_busy", busy, 1'b0);
    check("rst_wait_rdata", rdata, 32'h0);
    saw_hit = 1'b0;
    repeat (6) begin
      tick();
      saw_hit |= hit;
    end
    check("rst_wait_no_late_hit", saw_hit, 1'b0);
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, got);
    check("rst_wait_mem", got, 32'h1234_5678);

    // Reset on the edge leaving RESP discards the store.
    do_txn(1'b0, 1'b1, 32'h44, 32'h0BAD_F00D, 4'hF, lat, got);
    addr = 32'h44; wdata = 32'h5555_5555; wmask = 4'hF; wren = 1'b1;
    tick();
    wren = 1'b0;
    saw_hit = 1'b0;
    for (int k = 0; k < 40 && !saw_hit; k++) begin
      if (hit) saw_hit = 1'b1;
      else tick();
    end
    check("rst_resp_reached", saw_hit, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_rdata = '0;
    check("rst_resp_busy", busy, 1'b0);
    do_txn(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, lat, got);
    check("rst_resp_mem", got, 32'h0BAD_F00D);

    // Random traffic over a 16-word window with aliasing upper and offset bits.
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b0, 1'b1, 32'(i) << 2, $urandom(), 4'hF, lat, got);
    end
    for (int n = 0; n < 1000; n++) begin
      int          op;
      logic [31:0] ra;
      logic [3:0]  rm;
      op = int'($urandom_range(0, 2));
      ra = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      rm = 4'($urandom());
      do_txn(op != 1, op != 0, ra, $urandom(), rm, lat, got);
      check_range("rand_lat", lat, LAT + 1, LAT + 1 + EXTRA);
      check("rand_rdata", got, ref_rdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scholar_dmem_responder.md
# scholar_dmem_responder

Data-memory responder for the SCHOLAR RISC-V core's `d_m_*` port. It accepts the core's load/store requests and applies byte-masked writes to an internal word array. It answers each request with a one-cycle hit pulse after a configurable number of wait states. It sits outside the core in the simulation and FPGA platforms and exercises the non-perfect-memory path of the MEM and writeback stages.

## Interface
Parameters:
- `DataWidth`, 32: word width; 32 or 64 only, anything else is `$fatal`.
- `AddrWidth`, 32: byte address width.
- `DepthWords`, 1024: number of words in the array; power of two.
- `Latency`, 1: fixed wait states between request capture and hit; 0..15.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `d_m_addr_i`  in  AddrWidth  byte address of the request.
- `d_m_rden_i`  in  1  read request.
- `d_m_wren_i`  in  1  write request.
- `d_m_wdata_i`  in  DataWidth  store data.
- `d_m_wmask_i`  in  DataWidth/8  byte write enables.
- `d_m_rdata_o`  out  DataWidth  load data; registered.
- `d_m_hit_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  high while a request is captured and not yet completed.

## Operation
- FSM has three states: IDLE, WAIT, RESP. The reset state is IDLE.
- IDLE, when `d_m_rden_i || d_m_wren_i`:
  - Capture the address, wdata, wmask and op into registers.
  - If both rden and wren are high, the op is a write and the read is dropped.
  - Load the wait counter with `Latency` (+ extra, see Configuration).
  - Go to WAIT if the counter is nonzero, else go to RESP.
- WAIT: decrement the counter each cycle. When it reaches 0, go to RESP.
- RESP:
  - Assert `d_m_hit_o` for exactly one cycle, then return to IDLE.
  - Read: `d_m_rdata_o <= mem[idx]`, updated on the edge entering RESP.
  - Write: every byte `b` with `wmask[b]` set is updated on the edge leaving RESP; `d_m_rdata_o` is unchanged.
- Word index: `idx = addr[$clog2(DataWidth/8) +: $clog2(DepthWords)]`.
  - Low byte-offset bits are ignored.
  - Upper bits are ignored, so addresses alias (wrap) modulo the array size.
- `d_m_rdata_o` holds its value until the next read completes.
- Inputs are sampled only in IDLE. A request that changes or drops during WAIT still completes with its captured values.
- A write with `wmask == 0` completes with a hit and modifies nothing.
- `busy_o = (state != IDLE)`.

## Timing
- Reset values: `d_m_hit_o = 0`, `d_m_rdata_o = 0`, `busy_o = 0`, state IDLE, counter 0. Array contents are not cleared.
- A request first seen in IDLE at cycle t produces its hit at cycle t+1+N, where N is the total wait count. The minimum is t+1 when N = 0.
- Back-to-back requests: the core changes its request in the cycle after the hit. The next request is captured in IDLE one cycle after RESP. Steady-state throughput is one transaction per N+2 cycles.
- Read-after-write to the same word returns the new data, because the write lands before IDLE can capture the next request.
- Reset asserted mid-transaction:
  - The FSM goes to IDLE on that edge with no hit.
  - A write in RESP on that edge is discarded.
  - The core must reissue the request.

## Configuration
- `DMEM_RANDOM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 is seeded to `16'hACE1` on reset and advances every cycle.
  - At capture, the total wait count is `Latency + lfsr[1:0]`, i.e. 0..3 extra cycles.
- `DMEM_RANDOM_STALL_EN` not defined: the LFSR is absent and the total wait count is exactly `Latency`.

## Test plan
- Reset, then check outputs: hold `rst_i` 3 cycles → hit 0, rdata 0, busy 0, state IDLE.
- Write then read with `Latency = 2`, macro off: write addr `0x10`, data `0xDEADBEEF`, mask `4'hF`; hit exactly 3 cycles after the request is first seen. Then read addr `0x10` → rdata `0xDEADBEEF` on its hit, 3 cycles after the request.
- Byte mask: word holds `0x11223344`; write `0xAABBCCDD` with mask `4'b0101` → a following read returns `0x11BB33DD`.
- Aliasing and conflict, `DepthWords = 1024`, 32-bit: write `0x5` to addr `0x1000` → read of addr `0x0` returns `0x5`. rden and wren both high → write performed, rdata unchanged.
- Reset mid-transaction and mid-WAIT change: with `Latency = 3`, assert reset during WAIT → no hit, busy 0 next cycle, memory unchanged. Changing `d_m_addr_i` during WAIT → the response uses the captured address.
- Macro on, 1000 random transactions: every hit arrives between `Latency+1` and `Latency+4` cycles after capture, and data matches a reference model.
